// File: rtl/switch_irq_ctrl.sv
// APB3 switch/button interrupt controller: per-channel synchroniser, debouncer, edge detect,
// sticky W1C status and a maskable level IRQ. Define SWITCH_IRQ_EVCNT_EN for per-channel event counters.
module switch_irq_ctrl #(
    parameter int NCH     = 4,
    parameter int DB_BITS = 16
) (
    input  logic             PCLK,
    input  logic             PRESET,
    input  logic             PSEL,
    input  logic             PENABLE,
    input  logic             PWRITE,
    input  logic [31:0]      PADDR,
    input  logic [31:0]      PWDATA,
    output logic [31:0]      PRDATA,
    output logic             PREADY,
    output logic             PSLVERR,
    input  logic [NCH-1:0]   SW,
    output logic             IRQ,
    output logic [NCH-1:0]   EVT
);

`ifdef SWITCH_IRQ_EVCNT_EN
    localparam int          AW    = 5;
    localparam logic [15:0] ID_HI = 16'h5A18;
`else
    localparam int          AW    = 3;
    localparam logic [15:0] ID_HI = 16'h5A17;
`endif

    localparam logic [AW-1:0] A_LEVEL   = AW'(0);
    localparam logic [AW-1:0] A_STATUS  = AW'(1);
    localparam logic [AW-1:0] A_IRQ_EN  = AW'(2);
    localparam logic [AW-1:0] A_RISE_EN = AW'(3);
    localparam logic [AW-1:0] A_FALL_EN = AW'(4);
    localparam logic [AW-1:0] A_ID      = AW'(5);

    logic [AW-1:0]      reg_idx;
    logic               wr_en;
    logic [NCH-1:0]     wr_data;
    logic [NCH-1:0]     w1c;
    logic               unused_bits;

    logic [NCH-1:0]     sync_p0;
    logic [NCH-1:0]     sync_p1;
    logic [DB_BITS-1:0] cnt [NCH];
    logic [NCH-1:0]     db;
    logic [NCH-1:0]     db_q;
    logic [NCH-1:0]     rise;
    logic [NCH-1:0]     fall;
    logic [NCH-1:0]     ev;

    logic [NCH-1:0]     status;
    logic [NCH-1:0]     irq_en;
    logic [NCH-1:0]     rise_en;
    logic [NCH-1:0]     fall_en;
    logic [31:0]        rdata;

    assign reg_idx     = PADDR[AW+1:2];
    assign wr_en       = PSEL & PENABLE & PWRITE;
    assign wr_data     = PWDATA[NCH-1:0];
    assign w1c         = (wr_en && reg_idx == A_STATUS) ? wr_data : '0;
    assign unused_bits = ^{PADDR[31:AW+2], PADDR[1:0], PWDATA[31:NCH]};

    assign PREADY  = 1'b1;
    assign PSLVERR = 1'b0;

    // Stage p0/p1: two-flop synchroniser on the inverted (pressed = 1) switch inputs,
    // followed by the debounce counters which toggle db only after 2^DB_BITS stable cycles
    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            sync_p0 <= '0;
            sync_p1 <= '0;
            db      <= '0;
            db_q    <= '0;
            for (int i = 0; i < NCH; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            sync_p0 <= ~SW;
            sync_p1 <= sync_p0;
            db_q    <= db;
            for (int i = 0; i < NCH; i++) begin
                if (sync_p1[i] == db[i]) begin
                    cnt[i] <= '0;
                end else if (&cnt[i]) begin
                    cnt[i] <= '0;
                    db[i]  <= ~db[i];
                end else begin
                    cnt[i] <= cnt[i] + 1'b1;
                end
            end
        end
    end

    // Edge detect on the debounced level
    assign rise = db & ~db_q;
    assign fall = ~db & db_q;
    assign ev   = (rise & rise_en) | (fall & fall_en);

    // Control/status registers; a new event beats a simultaneous W1C of the same bit
    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            status  <= '0;
            irq_en  <= '0;
            rise_en <= '0;
            fall_en <= '0;
            IRQ     <= 1'b0;
            EVT     <= '0;
        end else begin
            status <= (status & ~w1c) | ev;
            if (wr_en && reg_idx == A_IRQ_EN)  irq_en  <= wr_data;
            if (wr_en && reg_idx == A_RISE_EN) rise_en <= wr_data;
            if (wr_en && reg_idx == A_FALL_EN) fall_en <= wr_data;
            IRQ <= |(status & irq_en);
            EVT <= ev;
        end
    end

`ifdef SWITCH_IRQ_EVCNT_EN
    logic [7:0] evcnt [NCH];

    // Saturating event counters; a clear coinciding with an event keeps that event
    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            for (int i = 0; i < NCH; i++) begin
                evcnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NCH; i++) begin
                if (wr_en && reg_idx == AW'(8 + i)) begin
                    evcnt[i] <= {7'd0, ev[i]};
                end else if (ev[i] && evcnt[i] != 8'hFF) begin
                    evcnt[i] <= evcnt[i] + 8'd1;
                end
            end
        end
    end
`endif

    always_comb begin
        rdata = '0;
        if (PSEL && !PWRITE) begin
            case (reg_idx)
                A_LEVEL:   rdata = 32'(db);
                A_STATUS:  rdata = 32'(status);
                A_IRQ_EN:  rdata = 32'(irq_en);
                A_RISE_EN: rdata = 32'(rise_en);
                A_FALL_EN: rdata = 32'(fall_en);
                A_ID:      rdata = {ID_HI, 8'(NCH), 8'(DB_BITS)};
                default:   rdata = '0;
            endcase
`ifdef SWITCH_IRQ_EVCNT_EN
            for (int i = 0; i < NCH; i++) begin
                if (reg_idx == AW'(8 + i)) rdata = 32'(evcnt[i]);
            end
`endif
        end
    end

    assign PRDATA = rdata;

endmodule

// File: doc/switch_irq_ctrl.md
# switch_irq_ctrl

Parametrised APB3 switch/button interrupt controller for the SmartFusion fabric. It debounces NCH active-low switch inputs and detects rising (press) and falling (release) edges per channel. Edges are latched into a sticky, write-1-to-clear status register. A single maskable level interrupt drives a fabric interrupt (FABINT) to the Cortex-M3, and firmware reads per-channel levels and events over APB3.

## Interface
Parameters:
- NCH, 4: number of switch channels, 1..16.
- DB_BITS, 16: debounce counter width; input must be stable for 2^DB_BITS cycles. Minimum 2.

Ports:
- PCLK  in  1  APB/fabric clock; all logic is on the rising edge.
- PRESET  in  1  synchronous, active-high reset.
- PSEL  in  1  peripheral select.
- PENABLE  in  1  APB access phase.
- PWRITE  in  1  1 = write, 0 = read.
- PADDR  in  32  byte address; only PADDR[4:2] is decoded.
- PWDATA  in  32  write data.
- PRDATA  out  32  read data.
- PREADY  out  1  tied to 1 (zero wait states).
- PSLVERR  out  1  tied to 0.
- SW  in  NCH  raw switch inputs, active-low (0 = pressed), asynchronous.
- IRQ  out  1  registered level interrupt, routed to FABINT.
- EVT  out  NCH  one-cycle pulse per channel on any enabled edge, unmasked.

## Operation
- Per channel: 2-flop synchroniser on ~SW, giving pressed = 1.
- Debouncer per channel:
  - The counter clears whenever the synchronised value equals the debounced level DB[i].
  - Otherwise the counter increments.
  - When the counter is all-ones and the values still differ, DB[i] toggles on the next edge and the counter clears.
- Edge detection on DB:
  - rise[i] = DB[i] & ~DB_q[i].
  - fall[i] = ~DB[i] & DB_q[i].
  - ev[i] = (rise[i] & RISE_EN[i]) | (fall[i] & FALL_EN[i]).
- STATUS[i] sets on ev[i] and clears on a write of 1 to that bit. If a set and a clear land in the same cycle, set wins.
- IRQ <= |(STATUS & IRQ_EN), registered.
- EVT[i] <= ev[i], registered.
- Register map (32-bit; bits above NCH read 0 and ignore writes):
  - 0x00 LEVEL: RO, DB[NCH-1:0].
  - 0x04 STATUS: R/W1C.
  - 0x08 IRQ_EN: RW.
  - 0x0C RISE_EN: RW.
  - 0x10 FALL_EN: RW.
  - 0x14 ID: RO, {16'h5A17, 8'(NCH), 8'(DB_BITS)}.
  - 0x18–0x1C: read 0, writes ignored.
- Write strobe is PSEL & PENABLE & PWRITE; it takes effect at the end of the access phase.
- PRDATA is a combinational decode of PADDR[4:2] while PSEL & ~PWRITE; otherwise 0.

## Timing
- Reset values:
  - Synchronisers, counters, DB, DB_q, STATUS, IRQ_EN, RISE_EN, FALL_EN, IRQ, EVT: all 0.
  - PRDATA: 0.
- Latency, with SW changing before edge 1 and held stable:
  - DB changes at edge 2^DB_BITS+2.
  - STATUS bit and EVT pulse at edge 2^DB_BITS+3.
  - IRQ at edge 2^DB_BITS+4.
- A glitch shorter than 2^DB_BITS cycles produces no DB change. Counter wrap is impossible because the counter clears on toggle.
- Write to IRQ_EN: IRQ reflects the new mask one edge after the write edge.
- W1C on the last set bit: IRQ deasserts one edge after the write edge.
- Reset mid-operation: all state clears in the same cycle. A switch held pressed through reset is re-debounced after reset and generates a rise event (if RISE_EN is set) 2^DB_BITS+3 edges after PRESET falls.
- Simultaneous edges on several channels set all corresponding STATUS bits in the same cycle.

## Configuration
- SWITCH_IRQ_EVCNT_EN defined:
  - Adds one 8-bit saturating event counter per channel, incremented on ev[i] and stopping at 0xFF.
  - Counters are readable at 0x20+4*i (i < NCH); any write there clears that counter.
  - PADDR[6:2] is decoded.
  - ID[31:16] reads 16'h5A18.
- SWITCH_IRQ_EVCNT_EN undefined:
  - No counters are built; PADDR[4:2] only.
  - Addresses at 0x20 and above alias the 0x00–0x1C map.

## Test plan
All scenarios use NCH=4, DB_BITS=4.
- Reset: assert PRESET for 3 cycles, then read all registers -> LEVEL=0, STATUS=0, enables=0, ID=0x5A170404; IRQ=0, EVT=0.
- Press debounce: set RISE_EN=0x1 and IRQ_EN=0x1, drive SW[0]=0 and hold -> LEVEL[0]=1 at edge 18, STATUS=0x1 and single EVT[0] pulse at edge 19, IRQ=1 at edge 20.
- Glitch reject: drive SW[1] low for 10 cycles, then high -> LEVEL, STATUS and EVT unchanged.
- W1C vs set collision: STATUS=0x1; write 0x1 to 0x04 in the same cycle a new channel-0 event occurs -> STATUS stays 0x1 and IRQ stays 1.
- Masking and fall: FALL_EN=0x4, IRQ_EN=0; release SW[2] after a press -> STATUS=0x4 and EVT[2] pulses, IRQ=0. Then write IRQ_EN=0x4 -> IRQ=1 one edge after the write edge.
- Reset mid-press: hold SW[3]=0 with RISE_EN=0x8, pulse PRESET at the debounce midpoint, then re-enable RISE_EN -> STATUS[3] sets 19 edges after PRESET falls.
